// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
//   ID-stage forwarding and load-use hazard controller. A small shift register
//   (entry 0 = EX ... entry NUM_STG-1 = WB) records every instruction that leaves
//   ID. Each ID source is compared against the tracked destinations to pick a
//   forwarding source and to detect reads of load data that is not ready yet.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   id_valid_i         ID holds a valid instruction
//   id_regwrite_i      ID instruction writes rd
//   id_is_load_i       ID instruction is a load
//   id_dest_i          ID rd
//   id_src_i           ID sources, src k at [k*REG_AW +: REG_AW]
//   mem_stall_i        memory stall, freezes the whole tracker
//   flush_i            IF/ID instruction is being squashed
//   fwd_sel_o          per source: 0 = register file, s+1 = result of stage s
//   stall_o            load-use stall, hold PC and IF/ID
//   perf_stall_cnt_o   count of advancing load-use stall cycles
//
// Configuration
//   HAZ_PERF_CNT_EN    when defined, builds the 32-bit stall counter; otherwise
//                      perf_stall_cnt_o is tied to zero and no counter exists.
//
// SEL_W must be at least clog2(NUM_STG+1) so that every stage select fits.

module hazard_forward_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned NUM_STG  = 3,
    parameter int unsigned LOAD_STG = 1,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid_i,
    input  logic                       id_regwrite_i,
    input  logic                       id_is_load_i,
    input  logic [REG_AW-1:0]          id_dest_i,
    input  logic [NUM_SRC*REG_AW-1:0]  id_src_i,
    input  logic                       mem_stall_i,
    input  logic                       flush_i,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
    output logic                       stall_o,
    output logic [31:0]                perf_stall_cnt_o
);

    // ------------------------------------------------------------------
    // In-flight writer tracking
    // ------------------------------------------------------------------
    logic [NUM_STG-1:0] vld_q;
    logic [NUM_STG-1:0] wr_q;
    logic [NUM_STG-1:0] ld_q;
    logic [REG_AW-1:0]  dst_q [NUM_STG];

    logic advance;
    logic take_id;

    assign advance = ~mem_stall_i;
    // A stalled or flushed ID instruction is replaced by a bubble in EX.
    assign take_id = id_valid_i & ~stall_o & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            wr_q  <= '0;
            ld_q  <= '0;
            for (int unsigned s = 0; s < NUM_STG; s++) begin
                dst_q[s] <= '0;
            end
        end else if (advance) begin
            for (int unsigned s = 1; s < NUM_STG; s++) begin
                vld_q[s] <= vld_q[s-1];
                wr_q[s]  <= wr_q[s-1];
                ld_q[s]  <= ld_q[s-1];
                dst_q[s] <= dst_q[s-1];
            end
            vld_q[0] <= take_id;
            wr_q[0]  <= take_id & id_regwrite_i;
            ld_q[0]  <= take_id & id_is_load_i;
            dst_q[0] <= take_id ? id_dest_i : '0;
        end
    end

    // ------------------------------------------------------------------
    // Source matching
    // ------------------------------------------------------------------
    // A stage only counts as a writer when it targets a real register;
    // x0 is hard-wired and must never be forwarded or stall anything.
    logic [NUM_STG-1:0] writer;

    always_comb begin
        writer = '0;
        for (int unsigned s = 0; s < NUM_STG; s++) begin
            writer[s] = vld_q[s] & wr_q[s] & (dst_q[s] != '0);
        end
    end

    logic [NUM_STG-1:0] hit [NUM_SRC];

    always_comb begin
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            hit[k] = '0;
            for (int unsigned s = 0; s < NUM_STG; s++) begin
                hit[k][s] = writer[s] & (dst_q[s] == id_src_i[k*REG_AW +: REG_AW]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Forwarding select: youngest (lowest index) matching stage wins
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] sel [NUM_SRC];

    always_comb begin
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            logic found;
            found  = 1'b0;
            sel[k] = '0;
            for (int unsigned s = 0; s < NUM_STG; s++) begin
                if (!found && hit[k][s]) begin
                    sel[k] = SEL_W'(s + 1);
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        fwd_sel_o = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            fwd_sel_o[k*SEL_W +: SEL_W] = sel[k];
        end
    end

    // ------------------------------------------------------------------
    // Load-use detection
    // ------------------------------------------------------------------
    // Stages before LOAD_STG have not produced load data yet; any matching
    // load there forces a stall, even when a younger non-load also matches.
    logic [NUM_STG-1:0] early_load;
    logic               load_hit;

    always_comb begin
        early_load = '0;
        for (int unsigned s = 0; s < NUM_STG; s++) begin
            early_load[s] = ld_q[s] & (s < LOAD_STG);
        end
    end

    always_comb begin
        load_hit = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            load_hit = load_hit | (|(hit[k] & early_load));
        end
    end

    // Flush wins over a load-use stall: the instruction is being dropped anyway.
    assign stall_o = id_valid_i & ~flush_i & load_hit;

    // ------------------------------------------------------------------
    // Performance counter
    // ------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_cnt_q;

    // Frozen cycles are not counted; only cycles that actually insert a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= 32'd0;
        end else if (stall_o && advance) begin
            perf_cnt_q <= perf_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_cnt_q;
`else
    assign perf_stall_cnt_o = 32'd0;
`endif

endmodule
